// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the bit-serial datapath cells.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/Done handshake bundle between a controlling FSM and serial_subtractor.
// Zero exists only when SERIAL_SUB_ZERO_FLAG_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    // Start is sampled only while Busy=0. A and B are captured on that same edge.
    // Done pulses for one cycle, and Diff/Borrow/Zero then hold until the next Done.
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             Zero;
`endif

    modport master (
        output Start, A, B,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        input  Zero,
`endif
        input  Busy, Done, Diff, Borrow
    );

    modport slave (
        input  Start, A, B,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        output Zero,
`endif
        output Busy, Done, Diff, Borrow
    );

endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor built from two half-subtractor stages and an OR.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    assign d1   = a ^ b;
    assign b1   = ~a & b;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, Diff = A - B, LSB first with a registered borrow.
// Optional Zero flag enabled by SERIAL_SUB_ZERO_FLAG_EN.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                Clk,
    input  logic                Rst_n,
    serial_subtractor_if.slave  bus,
    output sub_state_t          dbg_state
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > SUB_MAX_WIDTH) begin : g_bad_width
        $error("serial_subtractor: WIDTH out of range");
    end

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] part_q, part_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] full_res;

    full_subtractor_bit u_cell (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .bin (br_q),
        .d   (d_bit),
        .bout(br_next)
    );

    // The newest bit lands at the MSB; after WIDTH-1 shifts bit 0 sits at part_q[0].
    assign full_res = {d_bit, part_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        part_d   = part_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.Start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + 1'b1;
                part_d = full_res[WIDTH-1:1];
                if (cnt_q == CNT_LAST) begin
                    diff_d   = full_res;
                    borrow_d = br_next;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                    zero_d   = (full_res == '0);
`endif
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            part_q   <= part_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign bus.Busy   = (state_q == RUN);
    assign bus.Done   = (state_q == DONE);
    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    assign bus.Zero   = zero_q;
`endif
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (also builds with SERIAL_SUB_ZERO_FLAG_EN).
module tb_serial_subtractor;
  import arith_pkg::*;

  localparam int WIDTH = 8;
  localparam int EW    = WIDTH + 2;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();
  sub_state_t dbg_state;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];   // {zero, borrow, diff}

  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a - b;
    return {(d == '0), (a < b), d};
  endfunction

  function automatic logic zero_out();
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    return bus.Zero;
`else
    return 1'b1;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    exp_q.push_back(model(a, b));
    @(posedge Clk);
    #1 bus.Start = 1'b0;
  endtask

  // Counts negedges until Done; n=-1 on timeout, gap=1 if Busy dropped first.
  task automatic wait_done(output int n, output bit gap);
    n   = 0;
    gap = 1'b0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      @(negedge Clk);
      n++;
      if (bus.Done === 1'b1) return;
      if (bus.Busy !== 1'b1) gap = 1'b1;
    end
    n = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Rst_n     = 1'b0;
    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total++;
    if ({bus.Busy, bus.Done, bus.Borrow} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got busy/done/borrow=%b want 000", {bus.Busy, bus.Done, bus.Borrow});
    end
    total++;
    if (bus.Diff !== '0) begin
      bad++;
      $display("FAIL reset_diff got=%h want=00", bus.Diff);
    end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    total++;
    if (bus.Zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_zero got=%b want=1", bus.Zero);
    end
`endif
    total++;
    if (dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE);
    end
    Rst_n = 1'b1;
  endtask

  task automatic test_subtract();
    logic [WIDTH-1:0] va[10];
    logic [WIDTH-1:0] vb[10];
    logic [EW-1:0]    e;
    int               n;
    bit               gap;
    va[0] = 8'h35; vb[0] = 8'h12;
    va[1] = 8'h12; vb[1] = 8'h35;
    va[2] = 8'hFF; vb[2] = 8'hFF;
    va[3] = 8'h00; vb[3] = 8'h01;
    va[4] = 8'h80; vb[4] = 8'h7F;
    va[5] = 8'h7F; vb[5] = 8'h80;
    for (int i = 6; i < 10; i++) begin
      va[i] = WIDTH'($urandom_range(0, 255));
      vb[i] = WIDTH'($urandom_range(0, 255));
    end
    for (int i = 0; i < 10; i++) begin
      drive_op(va[i], vb[i]);
      wait_done(n, gap);
      total++;
      if (n != WIDTH + 1 || gap) begin
        bad++;
        $display("FAIL sub_latency[%0d] got negedges=%0d busy_gap=%0b want=%0d gap=0", i, n, gap, WIDTH + 1);
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      total++;
      if ({bus.Borrow, bus.Diff} !== e[WIDTH:0]) begin
        bad++;
        $display("FAIL sub_result[%0d] %h-%h got borrow=%b diff=%h want borrow=%b diff=%h",
                 i, va[i], vb[i], bus.Borrow, bus.Diff, e[WIDTH], e[WIDTH-1:0]);
      end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      total++;
      if (bus.Zero !== e[WIDTH+1]) begin
        bad++;
        $display("FAIL sub_zero[%0d] got=%b want=%b", i, bus.Zero, e[WIDTH+1]);
      end
`endif
      @(negedge Clk);
      total++;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || {bus.Borrow, bus.Diff} !== e[WIDTH:0]) begin
        bad++;
        $display("FAIL sub_hold[%0d] got done=%b busy=%b borrow=%b diff=%h want done=0 busy=0 borrow=%b diff=%h",
                 i, bus.Done, bus.Busy, bus.Borrow, bus.Diff, e[WIDTH], e[WIDTH-1:0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [EW-1:0] e;
    int            n;
    bit            gap;
    drive_op(8'h35, 8'h12);
    repeat (3) @(negedge Clk);
    bus.Start = 1'b1;
    bus.A     = 8'h77;
    bus.B     = 8'h11;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    wait_done(n, gap);
    total++;
    if (n != WIDTH + 1 - 3 || gap) begin
      bad++;
      $display("FAIL ignore_latency got negedges=%0d busy_gap=%0b want=%0d gap=0", n, gap, WIDTH - 2);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    total++;
    if ({bus.Borrow, bus.Diff} !== e[WIDTH:0]) begin
      bad++;
      $display("FAIL ignore_result got borrow=%b diff=%h want borrow=%b diff=%h",
               bus.Borrow, bus.Diff, e[WIDTH], e[WIDTH-1:0]);
    end
    @(negedge Clk);
    total++;
    if (dbg_state !== IDLE || bus.Busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_no_second_op got state=%0d busy=%b want state=%0d busy=0", dbg_state, bus.Busy, IDLE);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [EW-1:0] e;
    int            n;
    bit            gap;
    bit            seen;
    drive_op(8'h5A, 8'h0F);
    repeat (4) @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    total++;
    if ({bus.Busy, bus.Done, bus.Borrow} !== 3'b000 || bus.Diff !== '0 || zero_out() !== 1'b1) begin
      bad++;
      $display("FAIL abort_async got busy=%b done=%b borrow=%b diff=%h zero=%b want 0 0 0 00 1",
               bus.Busy, bus.Done, bus.Borrow, bus.Diff, zero_out());
    end
    exp_q.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    seen  = 1'b0;
    repeat (2 * WIDTH) begin
      @(negedge Clk);
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_no_done got activity=1 want=0");
    end
    drive_op(8'h35, 8'h12);
    wait_done(n, gap);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    total++;
    if (n != WIDTH + 1 || gap || {bus.Borrow, bus.Diff} !== e[WIDTH:0]) begin
      bad++;
      $display("FAIL abort_recover got negedges=%0d gap=%0b borrow=%b diff=%h want %0d 0 %b %h",
               n, gap, bus.Borrow, bus.Diff, WIDTH + 1, e[WIDTH], e[WIDTH-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [WIDTH-1:0] pa[N];
    logic [WIDTH-1:0] pb[N];
    logic [EW-1:0]    e;
    int               n;
    pa[0] = 8'h35; pb[0] = 8'h12;
    pa[1] = 8'h12; pb[1] = 8'h35;
    pa[2] = 8'hFF; pb[2] = 8'hFF;
    pa[3] = 8'h00; pb[3] = 8'h01;
    pa[4] = 8'h80; pb[4] = 8'h7F;
    pa[5] = 8'hC3; pb[5] = 8'h3C;
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.A     = pa[0];
    bus.B     = pb[0];
    exp_q.push_back(model(pa[0], pb[0]));
    @(negedge Clk);
    bus.A = pa[1];
    bus.B = pb[1];
    exp_q.push_back(model(pa[1], pb[1]));
    n = 1;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 4 * WIDTH; k++) begin
        @(negedge Clk);
        n++;
        if (bus.Done === 1'b1) break;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      total++;
      if (n != WIDTH + 1 || {bus.Borrow, bus.Diff} !== e[WIDTH:0]) begin
        bad++;
        $display("FAIL b2b[%0d] got spacing=%0d borrow=%b diff=%h want %0d %b %h",
                 i, n, bus.Borrow, bus.Diff, WIDTH + 1, e[WIDTH], e[WIDTH-1:0]);
      end
      @(negedge Clk);
      n = 1;
      total++;
      if (bus.Done !== 1'b0 || bus.Busy !== (i < N - 1)) begin
        bad++;
        $display("FAIL b2b_accept[%0d] got done=%b busy=%b want done=0 busy=%b",
                 i, bus.Done, bus.Busy, (i < N - 1));
      end
      if (i + 2 < N) begin
        bus.A = pa[i+2];
        bus.B = pb[i+2];
        exp_q.push_back(model(pa[i+2], pb[i+2]));
      end else begin
        bus.Start = 1'b0;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_subtract();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
